// File: rtl/spi_ram_pkg.sv
// Shared constants, FSM state type and opcode decode for the SPI RAM responder.
// Honors SPI_RAM_FAST_READ_EN: when defined, FAST READ (0x0B) is an accepted opcode.
package spi_ram_pkg;

  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE     = 8'h02;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  localparam int         SPI_ADDR_BITS     = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD,
    WR,
    IGNORE
  } spi_state_t;

  // Opcodes that proceed to the address phase; everything else is ignored.
  function automatic logic cmdAccepted(input logic [7:0] op);
`ifdef SPI_RAM_FAST_READ_EN
    return (op == SPI_CMD_READ) || (op == SPI_CMD_WRITE) || (op == SPI_CMD_FAST_READ);
`else
    return (op == SPI_CMD_READ) || (op == SPI_CMD_WRITE);
`endif
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte-wide memory with synchronous read; contents are never reset.
module spi_ram_mem #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_target.sv
// SPI mode-0 RAM responder: oversampled SPI front end, command FSM and byte memory.
// Honors SPI_RAM_FAST_READ_EN (adds FAST READ 0x0B with 8 dummy clocks).
module spi_ram_target
  import spi_ram_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic txn_done
);

  logic [1:0]        r_csSync;
  logic [1:0]        r_sclkSync;
  logic [1:0]        r_mosiSync;
  logic              r_sclkPrev;
  spi_state_t        r_state;
  spi_state_t        w_nextState;
  logic [5:0]        r_bitCnt;
  logic [7:0]        r_rxShift;
  logic [7:0]        r_opcode;
  logic [7:0]        r_txShift;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addrDone;
  logic              r_wrEn;
  logic              r_rdReq;
  logic              r_loadTx;
  logic              r_miso;
  logic              r_txnDone;
  logic              w_csActive;
  logic              w_sclkRise;
  logic              w_sclkFall;
  logic              w_mosi;
  logic [7:0]        w_rxNext;
  logic              w_cmdDone;
  logic              w_addrPhaseDone;
  logic              w_byteRise;
  logic              w_byteFall;
  logic              w_memRe;
  logic [7:0]        w_rdata;

  // Chip select resets to deasserted so the FSM stays idle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csSync   <= 2'b11;
      r_sclkSync <= 2'b00;
      r_mosiSync <= 2'b00;
      r_sclkPrev <= 1'b0;
    end else begin
      r_csSync   <= {r_csSync[0], spi_cs_n};
      r_sclkSync <= {r_sclkSync[0], spi_sclk};
      r_mosiSync <= {r_mosiSync[0], spi_mosi};
      r_sclkPrev <= r_sclkSync[1];
    end
  end

  assign w_csActive      = ~r_csSync[1];
  assign w_sclkRise      = r_sclkSync[1] & ~r_sclkPrev;
  assign w_sclkFall      = ~r_sclkSync[1] & r_sclkPrev;
  assign w_mosi          = r_mosiSync[1];
  assign w_rxNext        = {r_rxShift[6:0], w_mosi};
  assign w_cmdDone       = (r_state == CMD) && w_sclkRise && (r_bitCnt == 6'd7);
  assign w_addrPhaseDone = (r_state == ADDR) && w_sclkRise &&
                           (r_bitCnt == 6'(SPI_ADDR_BITS - 1));
  assign w_byteRise      = w_sclkRise && (r_bitCnt[2:0] == 3'd7);
  assign w_byteFall      = w_sclkFall && (r_bitCnt[2:0] == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_csActive) w_nextState = CMD;
      CMD:   if (w_cmdDone) w_nextState = cmdAccepted(w_rxNext) ? ADDR : IGNORE;
      ADDR: begin
        if (w_addrPhaseDone) begin
          if (r_opcode == SPI_CMD_WRITE) begin
            w_nextState = WR;
`ifdef SPI_RAM_FAST_READ_EN
          end else if (r_opcode == SPI_CMD_FAST_READ) begin
            w_nextState = DUMMY;
`endif
          end else begin
            w_nextState = RD;
          end
        end
      end
      DUMMY: if (w_sclkRise && (r_bitCnt == 6'd7)) w_nextState = RD;
      default: w_nextState = r_state;
    endcase
    if ((r_state != IDLE) && !w_csActive) begin
      w_nextState = IDLE;
    end
  end

  // MISO is combinationally gated by the raw chip select so it drops the moment CS rises.
  always_comb begin
    busy     = (r_state != IDLE) && w_csActive;
    spi_miso = (r_state == RD) && r_miso && !spi_cs_n;
    w_memRe  = (r_state == RD) && r_rdReq;
    txn_done = r_txnDone;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitCnt   <= '0;
      r_rxShift  <= '0;
      r_opcode   <= '0;
      r_txShift  <= '0;
      r_addr     <= '0;
      r_addrDone <= 1'b0;
      r_wrEn     <= 1'b0;
      r_rdReq    <= 1'b0;
      r_loadTx   <= 1'b0;
      r_miso     <= 1'b0;
      r_txnDone  <= 1'b0;
    end else begin
      if (r_state != w_nextState) begin
        r_bitCnt <= '0;
      end else if (((r_state == RD) && w_sclkFall) ||
                   ((r_state inside {CMD, ADDR, DUMMY, WR}) && w_sclkRise)) begin
        r_bitCnt <= r_bitCnt + 6'd1;
      end

      if (r_state == IDLE) begin
        r_rxShift <= '0;
      end else if ((r_state inside {CMD, WR}) && w_sclkRise) begin
        r_rxShift <= w_rxNext;
      end

      if (w_cmdDone) begin
        r_opcode <= w_rxNext;
      end

      // Shifting the address straight into r_addr keeps only the low ADDR_W bits.
      if ((r_state == ADDR) && w_sclkRise) begin
        r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
      end else if (r_wrEn || ((r_state == RD) && w_byteFall)) begin
        r_addr <= r_addr + 1'b1;
      end

      if (r_state == IDLE) begin
        r_addrDone <= 1'b0;
      end else if (w_addrPhaseDone) begin
        r_addrDone <= 1'b1;
      end

      r_wrEn    <= (r_state == WR) && w_byteRise;
      r_rdReq   <= ((w_nextState == RD) && (r_state != RD)) ||
                   ((r_state == RD) && w_byteFall);
      r_loadTx  <= w_memRe;
      r_txnDone <= (r_state != IDLE) && !w_csActive && r_addrDone;

      if (r_state != RD) begin
        r_txShift <= '0;
        r_miso    <= 1'b0;
      end else if (r_loadTx) begin
        r_txShift <= w_rdata;
      end else if (w_sclkFall) begin
        r_miso    <= r_txShift[7];
        r_txShift <= {r_txShift[6:0], 1'b0};
      end
    end
  end

  spi_ram_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (r_wrEn),
    .i_re    (w_memRe),
    .i_addr  (r_addr),
    .i_wdata (r_rxShift),
    .o_rdata (w_rdata)
  );

endmodule

// File: doc/spi_ram_target.md
# spi_ram_target

Synthesizable SPI RAM responder (target) for the SoC's shared SPI bus. It decodes the READ (0x03) and WRITE (0x02) command/24-bit-address/data sequences that the memory controller issues, and backs them with an internal byte-wide memory. It serves as the bench and FPGA stand-in for the external SPI RAM on `ram_cs_n`. SPI inputs are oversampled in the responder's own `clk` domain.

## Interface
- `DEPTH`, 4096: memory size in bytes; must be a power of two, minimum 16.
- `ADDR_W`, $clog2(DEPTH): number of SPI address LSBs used.
- `clk` in 1: responder clock; must satisfy f_clk ≥ 8× f_sclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_cs_n` in 1: chip select, active low, asynchronous to `clk`.
- `spi_sclk` in 1: SPI clock, mode 0, asynchronous to `clk`.
- `spi_mosi` in 1: serial data in, MSB first.
- `spi_miso` out 1: serial data out, MSB first.
- `busy` out 1: high while CS is asserted and the responder is not in IDLE.
- `txn_done` out 1: one-cycle pulse when CS deasserts after a complete command+address phase.

## Operation
- `spi_cs_n`, `spi_sclk` and `spi_mosi` each pass through a 2-flop synchronizer. The SCLK rise and fall are detected on the synchronized signal.
- Mode 0 sampling and driving:
  - MOSI is sampled on each detected SCLK rise.
  - MISO is updated on each detected SCLK fall.
- Shift order: command 8 bits, then address 24 bits, then data in whole bytes, all MSB first.
- FSM states:
  - IDLE: waits for CS low, then goes to CMD.
  - CMD: after 8 rises, the opcode is latched. 0x02 or 0x03 go to ADDR; any other opcode goes to IGNORE.
  - ADDR: after 24 rises, `addr_q` is latched from the low ADDR_W bits. The next state is RD for a read and WR for a write.
  - RD:
    - A memory read is issued in the cycle after the address completes. The byte loads into the TX shift register.
    - Bit 7 is driven on the following SCLK fall.
    - After each 8th fall, the address increments and the next byte is prefetched so it is ready before the next fall.
  - WR: each completed 8-bit byte is written to `mem[addr_q]` in the cycle after its 8th rise, then the address increments.
  - IGNORE: stays until CS goes high. MISO is 0.
- Any state returns to IDLE within 3 clk of CS going high. A partial byte is discarded and no write occurs for it.
- The address wraps modulo DEPTH; `DEPTH-1 + 1` goes to 0. Upper SPI address bits are ignored.
- Streaming reads and writes continue indefinitely while CS stays low.
- MISO is 0 in all states other than RD. No tri-state; the top level gates MISO with CS.
- `txn_done` fires only if the ADDR phase completed, whether or not any data bytes followed.

## Timing
- Reset values: `spi_miso`=0, `busy`=0, `txn_done`=0, FSM=IDLE, all counters and shift registers 0. Memory contents are not reset.
- Input-to-detect latency: 3 clk (2 synchronizer stages plus edge register).
- MISO is valid at most 4 clk after the SCLK fall. At ≥8× oversampling it is stable at least 4 clk before the next SCLK rise.
- Write commit: `mem` is updated at most 4 clk after the 8th SCLK rise of a byte.
- Memory is synchronous: read data is available 1 clk after the address is presented. A read and a write never occur in the same cycle.
- CS may deassert at any point:
  - Mid-command or mid-address: no side effects.
  - Mid-data: bytes already completed are kept.
- CS reassertion while the FSM is still in IDLE from the previous deassert is accepted. The minimum CS-high time is 4 clk.
- Reset during a transaction: immediate return to IDLE. Memory is unchanged except for a write already committed.

## Configuration
- `SPI_RAM_FAST_READ_EN`:
  - When defined, opcode 0x0B (FAST READ) is also decoded. After the 24 address bits, 8 dummy SCLK cycles follow (MOSI ignored), then data is returned as for 0x03.
  - When undefined, 0x0B goes to IGNORE.

## Structure
- Shared package `spi_ram_pkg`:
  - Opcode constants `SPI_CMD_READ`=0x03, `SPI_CMD_WRITE`=0x02, `SPI_CMD_FAST_READ`=0x0B.
  - FSM state enum: IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE.
  - `SPI_ADDR_BITS`=24.
- Sub-module `spi_ram_mem`: single-port, byte-wide, DEPTH×8, synchronous read, write enable.
- Top level contains the synchronizers, edge detect, FSM, bit counter (6 bits) and shift registers.

## Test plan
- Write then read:
  - Stimulus: CS low, send 0x02, 0x000010, then 0xDE 0xAD 0xBE 0xEF, CS high. Then CS low, send 0x03, 0x000010, clock 32 bits.
  - Response: MISO returns 0xDEADBEEF and `txn_done` pulses twice.
- Wrap-around:
  - Stimulus: write 0x11 0x22 to address DEPTH-1, then read 2 bytes from DEPTH-1.
  - Response: 0x11 then 0x22, with 0x22 stored at address 0.
- Abort mid-byte:
  - Stimulus: write to address 0x20, send 0x55 then 4 bits, raise CS.
  - Response: `mem[0x20]`=0x55, `mem[0x21]` unchanged, no `txn_done` lost.
- Unknown opcode:
  - Stimulus: send 0x9F followed by 40 bits.
  - Response: MISO=0 throughout, memory unchanged, `txn_done` not asserted.
- Reset mid-read:
  - Stimulus: assert `rst_n` low during the data phase of a 0x03 read.
  - Response: `busy`=0 and `spi_miso`=0 immediately; the next READ works normally.
- With `SPI_RAM_FAST_READ_EN` defined:
  - Stimulus: send 0x0B, address 0x000010, 8 dummy clocks, then 32 clocks.
  - Response: 0xDEADBEEF. Without the macro: MISO=0 throughout.
